sim_mailbox_monitor: RTL and testbench
======================================

# sim_mailbox_monitor

Multi-channel Wishbone snoop monitor for simulation benches; successor to the single-address mailbox check in the bench top. It passively observes the core's Wishbone master and decodes writes to up to NUM_CH runtime-programmable mailbox addresses, each with its own mode: exit/halt code, console byte stream, or write counter. It sequences end-of-test so console output is flushed before `done_o`, and enforces a cycle watchdog.

## Interface
- ADDR_W, 32, Wishbone address width
- DATA_W, 32, Wishbone data width (multiple of 8)
- NUM_CH, 2, mailbox channel count (1..8)
- FIFO_DEPTH, 16, console FIFO entries (power of two, ≥2)
- MAX_CYCLES, 500_000, watchdog limit in RUN cycles
- CNT_W, 32, cycle and write counter width
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- enable_i  in  1  start monitoring; sampled only in IDLE
- wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_i  in  1 each  snooped bus control
- wb_adr_i  in  ADDR_W  snooped address
- wb_dat_i  in  DATA_W  snooped write data
- wb_sel_i  in  DATA_W/8  snooped byte selects
- mbx_addr_i  in  NUM_CH*ADDR_W  channel addresses, ch0 in LSBs
- mbx_mode_i  in  NUM_CH*2  per-channel mode: 00 OFF, 01 EXIT, 10 CONSOLE, 11 COUNT
- con_valid_o / con_ready_i  out/in  1  console byte handshake
- con_data_o  out  8  console byte
- done_o, pass_o, fail_o, timeout_o  out  1 each  end-of-test status
- exit_code_o  out  8  last accepted exit code
- cycle_cnt_o  out  CNT_W  RUN cycles elapsed
- wr_cnt_o  out  CNT_W  writes to COUNT-mode channels
- drop_cnt_o  out  16  console bytes dropped on full FIFO, saturating

## Operation
- Commit = cyc & stb & we & ack & wb_sel_i[0] on a rising edge; stalled cycles before ack never commit.
- Channel match: wb_adr_i == channel address and mode != OFF; multiple matches → lowest index wins.
- EXIT: data[7:0]==8'h01 → pass; 8'hFF → fail; other codes ignored. On accept, latch exit_code_o and enter DRAIN.
- CONSOLE: push data[7:0]; if full (and no pop that cycle) drop, increment drop_cnt_o.
- COUNT: wr_cnt_o += 1, wraps.
- FSM: IDLE →(enable_i) RUN →(exit accepted | watchdog) DRAIN →(FIFO empty) DONE. DONE sticky until reset.
- RUN: cycle_cnt_o increments each cycle; at MAX_CYCLES set timeout_o, enter DRAIN. Freezes outside RUN.
- DRAIN/DONE: all bus commits ignored; FIFO keeps draining.
- Commits in IDLE are ignored.
- Exit and watchdog in the same cycle → exit wins, timeout_o stays 0.
- Full FIFO with simultaneous push and pop → both succeed.
- enable_i deassertion after IDLE has no effect.

## Timing
- All outputs reset to 0; FIFO empty; state IDLE. Async reset mid-operation clears everything immediately.
- Console: commit at edge T → con_valid_o high after T; pop on con_valid_o & con_ready_i.
- FIFO is first-word-fall-through; con_data_o stable while con_valid_o & !con_ready_i.
- Exit at edge T → pass_o/fail_o/exit_code_o valid after T; if FIFO empty, done_o after edge T+1.
- Watchdog: timeout_o and DRAIN entry at the edge where cycle_cnt_o reaches MAX_CYCLES.

## Configuration
- `SIM_MAILBOX_WDT_EN` defined: watchdog comparison active as above.
- Undefined: no watchdog; timeout_o tied 0; cycle_cnt_o still counts in RUN and wraps.

## Structure
- Package sim_mailbox_pkg: mbx_mode_e (OFF/EXIT/CONSOLE/COUNT), mbx_state_e (IDLE/RUN/DRAIN/DONE), EXIT_PASS=8'h01, EXIT_FAIL=8'hFF.
- Sub-module sim_mailbox_fifo: 8-bit FWFT FIFO, FIFO_DEPTH entries, push/pop/full/empty.

## Test plan
- ch0 EXIT @0x8000_1000, enable, write 0x0000_0001 with ack → pass_o=1, exit_code_o=8'h01, done_o one cycle after the accept edge.
- ch1 CONSOLE @0x8000_2000, write 'H','i', then ch0 exit 0xFF with con_ready_i=0 → done_o low until 8'h48 then 8'h69 popped, fail_o=1.
- cyc/stb/we held 5 cycles to the CONSOLE address, ack only on the 5th → exactly one FIFO entry.
- MAX_CYCLES=100, enable, no writes → timeout_o and done_o at cycle 100, pass_o=fail_o=0.
- FIFO_DEPTH=4, con_ready_i=0, 6 console writes 1..6 → bytes 1..4 delivered in order, drop_cnt_o=2.
- Assert rst_n low while in DRAIN → all outputs 0 without waiting for a clock edge; then enable and exit 0x01 → normal pass.

Source files
------------

// File: rtl/sim_mailbox_pkg.sv
// ============================================================================
// Module  : sim_mailbox_pkg
// Brief   : Shared types and constants for the simulation mailbox monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sim_mailbox_pkg;

  // Per-channel decode mode, two bits per channel on mbx_mode_i
  typedef enum logic [1:0] {
    OFF     = 2'b00,
    EXIT    = 2'b01,
    CONSOLE = 2'b10,
    COUNT   = 2'b11
  } mbx_mode_e;

  // End-of-test sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mbx_state_e;

  localparam logic [7:0] EXIT_PASS = 8'h01;
  localparam logic [7:0] EXIT_FAIL = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/sim_mailbox_monitor_if.sv
// ============================================================================
// Module  : sim_mailbox_monitor_if
// Brief   : Wishbone master-side signals as seen by a passive snoop monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sim_mailbox_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                cyc;
  logic                stb;
  logic                we;
  logic                ack;
  logic [ADDR_W-1:0]   adr;
  logic [DATA_W-1:0]   dat;
  logic [DATA_W/8-1:0] sel;

  // Bus side driving the transfer (core / bench)
  modport master (output cyc, stb, we, ack, adr, dat, sel);
  // Snooping side: everything is input, nothing is driven back
  modport slave  (input  cyc, stb, we, ack, adr, dat, sel);
endinterface

`default_nettype wire

// File: rtl/sim_mailbox_fifo.sv
// ============================================================================
// Module  : sim_mailbox_fifo
// Brief   : 8-bit first-word-fall-through FIFO for console bytes. A push into
//           a full FIFO succeeds when a pop happens in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_mailbox_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam int c_aw = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [c_aw:0] r_wr;
  logic [c_aw:0] r_rd;
  logic        w_push_ok;
  logic        w_pop_ok;

  // Extra pointer MSB distinguishes full from empty
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[c_aw] != r_rd[c_aw]) && (r_wr[c_aw-1:0] == r_rd[c_aw-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  // Head is gated so the output reads 0 whenever nothing is queued
  assign o_data    = o_empty ? 8'h00 : r_mem[r_rd[c_aw-1:0]];

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr[c_aw-1:0]] <= i_data;
  end

  // Read/write pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop_ok)  r_rd <= r_rd + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sim_mailbox_monitor.sv
// ============================================================================
// Module  : sim_mailbox_monitor
// Brief   : Passive Wishbone snoop with NUM_CH programmable mailbox channels
//           (EXIT / CONSOLE / COUNT), console flush before done_o, and an
//           optional RUN-cycle watchdog enabled by SIM_MAILBOX_WDT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_mailbox_monitor
  import sim_mailbox_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_CYCLES = 500_000,
  parameter int CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  sim_mailbox_monitor_if.slave   wb,
  input  logic [NUM_CH*ADDR_W-1:0] mbx_addr_i,
  input  logic [NUM_CH*2-1:0]    mbx_mode_i,
  output logic                   con_valid_o,
  input  logic                   con_ready_i,
  output logic [7:0]             con_data_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   fail_o,
  output logic                   timeout_o,
  output logic [7:0]             exit_code_o,
  output logic [CNT_W-1:0]       cycle_cnt_o,
  output logic [CNT_W-1:0]       wr_cnt_o,
  output logic [15:0]            drop_cnt_o
);

  mbx_state_e       r_state, w_state_nxt;
  mbx_mode_e        w_mode;
  logic             w_hit, w_commit, w_active;
  logic             w_exit, w_push, w_pop, w_drop, w_cnt, w_wdt;
  logic             w_full, w_empty;
  logic [7:0]       w_byte;
  logic             r_pass, r_fail;
  logic [7:0]       r_exit_code;
  logic [CNT_W-1:0] r_cycle_cnt, r_wr_cnt;
  logic [15:0]      r_drop_cnt;
  logic             w_unused_bits;

  // Only the low byte carries mailbox payload
  assign w_byte        = wb.dat[7:0];
  assign w_unused_bits = ^{wb.dat, wb.sel};

  // A transfer lands only on the acked edge and needs lane 0 enabled
  assign w_commit = wb.cyc && wb.stb && wb.we && wb.ack && wb.sel[0];

  // Channel decode: scan high to low so the lowest matching index wins
  always_comb begin
    w_hit  = 1'b0;
    w_mode = OFF;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ((mbx_addr_i[i*ADDR_W +: ADDR_W] == wb.adr) && (mbx_mode_i[i*2 +: 2] != 2'b00)) begin
        w_hit  = 1'b1;
        w_mode = mbx_mode_e'(mbx_mode_i[i*2 +: 2]);
      end
    end
  end

  assign w_active = w_commit && w_hit && (r_state == RUN);
  assign w_exit   = w_active && (w_mode == EXIT) && ((w_byte == EXIT_PASS) || (w_byte == EXIT_FAIL));
  assign w_push   = w_active && (w_mode == CONSOLE);
  assign w_cnt    = w_active && (w_mode == COUNT);
  assign w_pop    = con_valid_o && con_ready_i;
  assign w_drop   = w_push && w_full && !w_pop;

`ifdef SIM_MAILBOX_WDT_EN
  localparam logic [CNT_W-1:0] c_wdt_last = CNT_W'(MAX_CYCLES - 1);
  logic r_timeout;
  assign w_wdt     = (r_state == RUN) && (r_cycle_cnt == c_wdt_last);
  assign timeout_o = r_timeout;

  // Watchdog flag; an exit on the same edge takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_timeout <= 1'b0;
    else if (w_wdt && !w_exit) r_timeout <= 1'b1;
  end
`else
  assign w_wdt     = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: run on enable, drain on exit/watchdog, finish once flushed
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable_i)       w_state_nxt = RUN;
      RUN:     if (w_exit || w_wdt) w_state_nxt = DRAIN;
      DRAIN:   if (w_empty)        w_state_nxt = DONE;
      default: w_state_nxt = DONE;
    endcase
  end

  // Status and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_exit_code <= 8'h00;
      r_cycle_cnt <= '0;
      r_wr_cnt    <= '0;
      r_drop_cnt  <= 16'h0000;
    end else begin
      if (w_exit) begin
        r_pass      <= (w_byte == EXIT_PASS);
        r_fail      <= (w_byte == EXIT_FAIL);
        r_exit_code <= w_byte;
      end
      if (r_state == RUN)                 r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_cnt)                          r_wr_cnt    <= r_wr_cnt + 1'b1;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  sim_mailbox_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_byte),
    .i_pop   (w_pop),
    .o_data  (con_data_o),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign con_valid_o = !w_empty;
  assign done_o      = (r_state == DONE);
  assign pass_o      = r_pass;
  assign fail_o      = r_fail;
  assign exit_code_o = r_exit_code;
  assign cycle_cnt_o = r_cycle_cnt;
  assign wr_cnt_o    = r_wr_cnt;
  assign drop_cnt_o  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sim_mailbox_monitor.sv
// ============================================================================
// Module  : tb_sim_mailbox_monitor
// Brief   : Directed bench for sim_mailbox_monitor; console bytes are checked
//           by a scoreboard queue, status outputs by directed comparisons.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sim_mailbox_monitor;

  localparam int AW = 32, DW = 32, NCH = 2, FD = 4, MC = 100, CW = 32;
  localparam logic [31:0] A_EXIT = 32'h8000_1000;
  localparam logic [31:0] A_CON  = 32'h8000_2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic con_ready = 1'b0;
  logic [NCH*AW-1:0] mbx_addr;
  logic [NCH*2-1:0]  mbx_mode;
  logic       con_valid, done, pass, fail, timeout;
  logic [7:0] con_data, exit_code;
  logic [CW-1:0] cycle_cnt, wr_cnt;
  logic [15:0] drop_cnt;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;

  sim_mailbox_monitor_if #(.ADDR_W(AW), .DATA_W(DW)) wb_if ();

  sim_mailbox_monitor #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_CH(NCH), .FIFO_DEPTH(FD),
    .MAX_CYCLES(MC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .wb(wb_if),
    .mbx_addr_i(mbx_addr), .mbx_mode_i(mbx_mode),
    .con_valid_o(con_valid), .con_ready_i(con_ready), .con_data_o(con_data),
    .done_o(done), .pass_o(pass), .fail_o(fail), .timeout_o(timeout),
    .exit_code_o(exit_code), .cycle_cnt_o(cycle_cnt), .wr_cnt_o(wr_cnt),
    .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  // Console monitor: every handshake pops one expected byte
  always @(negedge clk) begin
    if (rst_n && con_valid && con_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL con_extra: got %02h expected no byte", con_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (con_data === sb_exp) n_pass++;
        else $display("FAIL con_data: got %02h expected %02h", con_data, sb_exp);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"},  {31'd0, done},      32'd0);
    check({tag, "_pass"},  {31'd0, pass},      32'd0);
    check({tag, "_fail"},  {31'd0, fail},      32'd0);
    check({tag, "_tmo"},   {31'd0, timeout},   32'd0);
    check({tag, "_valid"}, {31'd0, con_valid}, 32'd0);
    check({tag, "_cdata"}, {24'd0, con_data},  32'd0);
    check({tag, "_code"},  {24'd0, exit_code}, 32'd0);
    check({tag, "_cyc"},   cycle_cnt,          32'd0);
    check({tag, "_wr"},    wr_cnt,             32'd0);
    check({tag, "_drop"},  {16'd0, drop_cnt},  32'd0);
  endtask

  task automatic bus_idle();
    wb_if.cyc = 1'b0; wb_if.stb = 1'b0; wb_if.we = 1'b0; wb_if.ack = 1'b0;
    wb_if.adr = '0;   wb_if.dat = '0;   wb_if.sel = '0;
  endtask

  // Asserts reset off-edge, checks outputs cleared with no clock, releases
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic start();
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
  endtask

  // Single-cycle acked write; commit lands on the second edge
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    @(posedge clk); #1;
    wb_if.cyc = 1'b1; wb_if.stb = 1'b1; wb_if.we = 1'b1; wb_if.ack = 1'b1;
    wb_if.adr = a; wb_if.dat = d; wb_if.sel = s;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus_idle();
    mbx_addr = {A_CON, A_EXIT};
    mbx_mode = {2'b10, 2'b01};
    #12;

    // ---- T1: basic pass, idle/drain commits ignored ----
    do_reset("rst0");
    wb_write(A_CON, 32'h41);
    check("idle_con_ignored", {31'd0, con_valid}, 32'd0);
    wb_write(A_EXIT, 32'h01);
    check("idle_exit_ignored", {31'd0, pass}, 32'd0);
    start();
    check("run_cyc_start", cycle_cnt, 32'd0);
    wb_write(A_EXIT, 32'h05);
    check("odd_code_ignored", {24'd0, exit_code}, 32'h00);
    wb_write(A_EXIT, 32'h0000_0001);
    check("pass_set", {31'd0, pass}, 32'd1);
    check("pass_code", {24'd0, exit_code}, 32'h01);
    check("done_not_yet", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check("pass_done", {31'd0, done}, 32'd1);
    check("pass_fail0", {31'd0, fail}, 32'd0);
    check("pass_tmo0", {31'd0, timeout}, 32'd0);
    wb_write(A_CON, 32'h42);
    check("done_con_ignored", {31'd0, con_valid}, 32'd0);
    check("done_sticky", {31'd0, done}, 32'd1);
    check("cyc_frozen", cycle_cnt, 32'd4);

    // ---- T2: console flush before done, fail exit ----
    do_reset("rst1");
    start();
    wb_write(A_CON, 32'h48); exp_q.push_back(8'h48);
    wb_write(A_CON, 32'h69); exp_q.push_back(8'h69);
    wb_write(A_EXIT, 32'hFF);
    check("fail_set", {31'd0, fail}, 32'd1);
    check("fail_pass0", {31'd0, pass}, 32'd0);
    check("fail_code", {24'd0, exit_code}, 32'hFF);
    repeat (3) begin @(posedge clk); #1; end
    check("drain_hold_done", {31'd0, done}, 32'd0);
    check("drain_valid", {31'd0, con_valid}, 32'd1);
    check("drain_head_stable", {24'd0, con_data}, 32'h48);
    con_ready = 1'b1;
    wait_done(20);
    check("drain_done", {31'd0, done}, 32'd1);
    check("drain_sb_empty", exp_q.size(), 32'd0);
    con_ready = 1'b0;

    // ---- T3: stalled write, COUNT mode, channel priority ----
    do_reset("rst2");
    start();
    @(posedge clk); #1;
    wb_if.cyc = 1'b1; wb_if.stb = 1'b1; wb_if.we = 1'b1; wb_if.ack = 1'b0;
    wb_if.adr = A_CON; wb_if.dat = 32'h5A; wb_if.sel = 4'hF;
    repeat (4) begin @(posedge clk); #1; end
    check("stall_no_push", {31'd0, con_valid}, 32'd0);
    wb_if.ack = 1'b1;
    @(posedge clk); #1;
    bus_idle();
    exp_q.push_back(8'h5A);
    check("stall_push", {31'd0, con_valid}, 32'd1);
    con_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("stall_one_entry", {31'd0, con_valid}, 32'd0);
    con_ready = 1'b0;
    mbx_addr = {A_EXIT, A_EXIT};
    mbx_mode = {2'b10, 2'b11};
    wb_write(A_EXIT, 32'h11);
    wb_write(A_EXIT, 32'h12);
    wb_write(A_EXIT, 32'h13, 4'b1110);
    wb_write(A_EXIT, 32'h14);
    check("count_wr", wr_cnt, 32'd3);
    check("lowest_wins", {31'd0, con_valid}, 32'd0);
    mbx_mode = {2'b10, 2'b00};
    wb_write(A_EXIT, 32'h77); exp_q.push_back(8'h77);
    check("off_skipped", {31'd0, con_valid}, 32'd1);
    check("count_kept", wr_cnt, 32'd3);
    con_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    con_ready = 1'b0;
    mbx_addr = {A_CON, A_EXIT};
    mbx_mode = {2'b10, 2'b01};

    // ---- T4: watchdog ----
    do_reset("rst3");
    start();
`ifdef SIM_MAILBOX_WDT_EN
    for (int i = 0; i < 200; i++) begin
      if (timeout) break;
      @(posedge clk); #1;
    end
    check("wdt_timeout", {31'd0, timeout}, 32'd1);
    check("wdt_cyc", cycle_cnt, 32'd100);
    check("wdt_pass0", {31'd0, pass}, 32'd0);
    check("wdt_fail0", {31'd0, fail}, 32'd0);
    @(posedge clk); #1;
    check("wdt_done", {31'd0, done}, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    check("wdt_cyc_frozen", cycle_cnt, 32'd100);
`else
    repeat (150) begin @(posedge clk); #1; end
    check("nowdt_cyc", cycle_cnt, 32'd150);
    check("nowdt_tmo0", {31'd0, timeout}, 32'd0);
    check("nowdt_done0", {31'd0, done}, 32'd0);
`endif

    // ---- T4b: exit on the watchdog edge wins ----
    do_reset("rst4");
    start();
    repeat (98) begin @(posedge clk); #1; end
    wb_write(A_EXIT, 32'h01);
    check("tie_pass", {31'd0, pass}, 32'd1);
    check("tie_tmo0", {31'd0, timeout}, 32'd0);
    check("tie_cyc", cycle_cnt, 32'd100);
    @(posedge clk); #1;
    check("tie_done", {31'd0, done}, 32'd1);

    // ---- T5: overflow drops, push+pop while full ----
    do_reset("rst5");
    start();
    for (int v = 1; v <= 6; v++) begin
      wb_write(A_CON, 32'(v));
      if (v <= 4) exp_q.push_back(8'(v));
    end
    check("ovf_drop", {16'd0, drop_cnt}, 32'd2);
    check("ovf_head", {24'd0, con_data}, 32'h01);
    @(posedge clk); #1;
    wb_if.cyc = 1'b1; wb_if.stb = 1'b1; wb_if.we = 1'b1; wb_if.ack = 1'b1;
    wb_if.adr = A_CON; wb_if.dat = 32'h07; wb_if.sel = 4'hF;
    con_ready = 1'b1;
    @(posedge clk); #1;
    bus_idle();
    exp_q.push_back(8'h07);
    check("full_pushpop_drop", {16'd0, drop_cnt}, 32'd2);
    repeat (8) begin @(posedge clk); #1; end
    check("ovf_drained", {31'd0, con_valid}, 32'd0);
    check("ovf_sb_empty", exp_q.size(), 32'd0);
    con_ready = 1'b0;

    // ---- T6: async reset during DRAIN, then normal run ----
    do_reset("rst6");
    start();
    wb_write(A_CON, 32'hAB); exp_q.push_back(8'hAB);
    wb_write(A_EXIT, 32'h01);
    @(posedge clk); #1;
    check("in_drain", {31'd0, done}, 32'd0);
    #2;
    do_reset("rst_async");
    start();
    wb_write(A_EXIT, 32'h01);
    check("post_rst_pass", {31'd0, pass}, 32'd1);
    @(posedge clk); #1;
    check("post_rst_done", {31'd0, done}, 32'd1);

    check("sb_final_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
